// File: rtl/dadda_mul16_seq.sv
// rtl/dadda_mul16_seq.sv - 16x16 unsigned multiplier sequenced over a shared external 8x8 Dadda core
// Four partial products (lo*lo, lo*hi, hi*lo, hi*hi) are accumulated one per cycle into a 32-bit product.
module dadda_mul16_seq #(
  parameter int BIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*BIT-1:0]   in_a,
  input  logic [2*BIT-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*BIT-1:0]   out_p,
  output logic               busy,
  output logic [BIT-1:0]     core_a,
  output logic [BIT-1:0]     core_b,
  input  logic [2*BIT-1:0]   core_p
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_step;
  logic [2*BIT-1:0]   r_a;
  logic [2*BIT-1:0]   r_b;
  logic [4*BIT-1:0]   r_acc;
  logic [4*BIT-1:0]   w_pp;
  logic               w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Step bit 1 selects the high half of A, step bit 0 the high half of B.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    core_a    = '0;
    core_b    = '0;
    out_valid = 1'b0;
    out_p     = '0;
    case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = rst_n;
        if (in_valid) begin
          w_next = S_MUL;
        end
      end
      S_MUL: begin
        core_a = r_step[1] ? r_a[2*BIT-1:BIT] : r_a[BIT-1:0];
        core_b = r_step[0] ? r_b[2*BIT-1:BIT] : r_b[BIT-1:0];
        if (r_step == 2'd3) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_p     = r_acc;
        in_ready  = out_ready;
        if (out_ready) begin
          w_next = in_valid ? S_MUL : S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_pp = '0;
    case (r_step)
      2'd0:    w_pp = {{(2*BIT){1'b0}}, core_p};
      2'd1,
      2'd2:    w_pp = {{BIT{1'b0}}, core_p, {BIT{1'b0}}};
      default: w_pp = {core_p, {(2*BIT){1'b0}}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_step <= 2'd0;
      r_acc  <= '0;
    end else if (w_accept) begin
      r_a    <= in_a;
      r_b    <= in_b;
      r_step <= 2'd0;
      r_acc  <= '0;
    end else if (r_state == S_MUL) begin
      r_acc  <= r_acc + w_pp;
      r_step <= r_step + 2'd1;
    end
  end

endmodule

// File: doc/dadda_mul16_seq.md
DADDA_MUL16_SEQ -- requirements
Module: dadda_mul16_seq

Interface
REQ-001 Parameter: BIT, 8, operand width of the shared 8x8 multiplier core; operand width is 2*BIT; only 8 is supported.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  request carries a valid operand pair.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 in_a  input  16  multiplicand, unsigned.
REQ-007 in_b  input  16  multiplier, unsigned.
REQ-008 out_valid  output  1  out_p holds a finished product.
REQ-009 out_ready  input  1  consumer takes the product this cycle.
REQ-010 out_p  output  32  unsigned product in_a*in_b.
REQ-011 busy  output  1  high in every state other than IDLE.
REQ-012 core_a  output  8  operand A driven to the external 8x8 Dadda core.
REQ-013 core_b  output  8  operand B driven to the external 8x8 Dadda core.
REQ-014 core_p  input  16  combinational product core_a*core_b from the core, valid in the same cycle.

Function
REQ-015 The block SHALL have three states: IDLE, MUL, DONE.
REQ-016 A request SHALL be accepted on a rising edge where in_valid and in_ready are both high; in_a/in_b SHALL be captured into registers at that edge.
REQ-017 in_ready SHALL be high in IDLE, high in DONE only while out_ready is high, and low in MUL.
REQ-018 Acceptance SHALL move the block to MUL with step counter 0 and accumulator 0.
REQ-019 In MUL the block SHALL run exactly four steps, one per cycle: step 0 a_lo*b_lo, step 1 a_lo*b_hi, step 2 a_hi*b_lo, step 3 a_hi*b_hi.
REQ-020 Each step SHALL add core_p to the 32-bit accumulator, shifted left by 0 (step 0), 8 (steps 1 and 2) or 16 (step 3); the sum never exceeds 32 bits and SHALL NOT be truncated.
REQ-021 After step 3 the block SHALL enter DONE with out_p equal to the final accumulator and out_valid high.
REQ-022 Latency: accept at edge T; out_valid SHALL first be high in the cycle after edge T+4 (four MUL cycles).
REQ-023 In DONE, out_valid and out_p SHALL be held stable until out_ready is high (back-pressure).
REQ-024 DONE with out_ready high and in_valid low SHALL go to IDLE; DONE with out_ready and in_valid both high SHALL complete the output and accept the new request on the same edge, going directly to MUL with step counter 0.
REQ-025 core_a and core_b SHALL be 0 in IDLE and DONE; in MUL they SHALL come only from the captured registers, never from live in_a/in_b.
REQ-026 Changes on in_a/in_b/in_valid during MUL or DONE SHALL have no effect.
REQ-027 out_p SHALL read 0 whenever out_valid is low.

Reset
REQ-028 While rst_n is low: state IDLE, step counter 0, accumulator 0, operand registers 0, out_valid 0, out_p 0, busy 0, core_a 0, core_b 0; in_ready SHALL go high on release.
REQ-029 Reset asserted mid-operation (MUL or DONE) SHALL abort immediately, without a delayed out_valid for the aborted request.
REQ-030 The first request after rst_n rises SHALL be accepted on the first edge where in_valid is high.

Verification
REQ-031 in_a=0x1234, in_b=0x5678, out_ready=1 -> out_valid high after four MUL cycles, out_p=0x06260060, then IDLE.
REQ-032 in_a=0xFFFF, in_b=0xFFFF -> out_p=0xFFFE0001; core_a/core_b sequence FF/FF on every step; in_a=0x0000, in_b=0xABCD -> out_p=0.
REQ-033 Back-pressure: out_ready=0 for 10 cycles after completion -> out_valid and out_p held constant, in_ready low, new in_valid ignored; out_ready=1 -> single transfer.
REQ-034 Back-to-back: in_valid held high with 0x0002*0x0003 then 0x0100*0x0100, out_ready=1 -> outputs 0x00000006 and 0x00010000, five-cycle spacing, second request accepted on the first result's output edge.
REQ-035 rst_n pulsed low during MUL step 2 -> all outputs 0 at once, no out_valid afterwards; next request 0x0010*0x0010 -> out_p=0x00000100.
REQ-036 Random test: 10,000 random operand pairs with random out_ready stalls -> every out_p equals the 32-bit reference product, in order, none lost or duplicated.
